full_adder_core: RTL and testbench



---
 rtl/full_adder_core.sv | 68 ++++++
 tb/tb_full_adder_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_core.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_core
// Purpose  : Width-parameterisable ripple-carry full adder with a combinational
//            result and a one-cycle registered copy qualified by out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             valid_d;
    logic             valid_q;

    // Ripple chain evaluated inside one process so the carry vector never
    // looks like a combinational loop between separate drivers.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sum;
            cout_d = cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_core.sv
`default_nettype none
// Bench for full_adder_core: directed WIDTH=1 / WIDTH=8 vectors plus a random
// WIDTH=8 run; registered results are checked through a queue-based scoreboard.
module tb_full_adder_core;

    logic       clk = 1'b0;
    logic       rst;

    logic       a1, b1, c1, iv1;
    logic       s1, co1, sq1, coq1, ov1;

    logic [7:0] a8, b8, s8, sq8;
    logic       c8, iv8, co8, coq8, ov8;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];
    logic [8:0] hold_exp = '0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(iv1),
        .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(coq1), .out_valid(ov1)
    );

    full_adder_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(iv8),
        .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(coq8), .out_valid(ov8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the 8-bit registered path.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ov8) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: out_valid=1 with no expected entry at %0t", $time);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("sb_result", {23'd0, coq8, sq8}, {23'd0, e});
                    hold_exp = e;
                end
            end else begin
                check("sb_hold", {23'd0, coq8, sq8}, {23'd0, hold_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Walk vectors: a, b, cin, expected sum, expected cout
    logic [4:0] walk [5] = '{5'b010_10, 5'b110_01, 5'b111_11, 5'b000_00, 5'b011_01};

    initial begin
        rst = 1'b0;
        a1 = 0; b1 = 0; c1 = 0; iv1 = 0;
        a8 = 0; b8 = 0; c8 = 0; iv8 = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_dut1", {29'd0, ov1, coq1, sq1}, 32'd0);
        check("rst_dut8", {22'd0, ov8, coq8, sq8}, 32'd0);

        // Combinational walk while reset is still held.
        for (int i = 0; i < 5; i++) begin
            logic [4:0] v;
            v = walk[i];
            {a1, b1, c1} = v[4:2];
            #1;
            check($sformatf("walk%0d", i), {30'd0, co1, s1}, {30'd0, v[0], v[1]});
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            logic [1:0] ref2;
            abc = i[2:0];
            {a1, b1, c1} = abc;
            ref2 = {1'b0, abc[2]} + {1'b0, abc[1]} + {1'b0, abc[0]};
            #2;
            check($sformatf("tt%0d", i), {30'd0, co1, s1}, {30'd0, ref2});
        end

        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
        check("w8_ff_01_0", {23'd0, co8, s8}, 32'h100);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
        check("w8_ff_ff_1", {23'd0, co8, s8}, 32'h1FF);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
        check("w8_00_00_0", {23'd0, co8, s8}, 32'h000);

        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        // WIDTH=1 registered path.
        {a1, b1, c1} = 3'b111; iv1 = 1'b1;
        @(posedge clk); #1;
        check("reg1_capture", {29'd0, ov1, coq1, sq1}, 32'b111);
        {a1, b1, c1} = 3'b000; iv1 = 1'b0;
        @(posedge clk); #1;
        check("reg1_hold", {29'd0, ov1, coq1, sq1}, 32'b011);
        {a1, b1, c1} = 3'b101; iv1 = 1'b1;
        @(posedge clk); #1;
        check("reg1_capture2", {29'd0, ov1, coq1, sq1}, 32'b110);
        iv1 = 1'b0;

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1;
        check("async_rst_dut1", {29'd0, ov1, coq1, sq1}, 32'd0);
        sb_q.delete();
        hold_exp = '0;
        check("rst_comb_track", {30'd0, co1, s1}, 32'b10);
        a1 = 1'b0; #1;
        check("rst_comb_track2", {30'd0, co1, s1}, 32'b01);
        @(posedge clk); #1 rst = 1'b0;

        // WIDTH=8 boundary vectors back to back through the register.
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; iv8 = 1'b1; sb_q.push_back(9'h100);
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; sb_q.push_back(9'h1FF);
        @(posedge clk); #1;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; sb_q.push_back(9'h000);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'h5A;
        @(posedge clk); #1;
        check("ov8_drop", {31'd0, ov8}, 32'd0);

        // Random regression with a reset pulse in the middle.
        for (int i = 0; i < 1000; i++) begin
            logic [8:0] r9;
            @(posedge clk); #1;
            if (i == 500) begin
                iv8 = 1'b1;
                #3 rst = 1'b1;
                #1;
                check("async_rst_dut8", {22'd0, ov8, coq8, sq8}, 32'd0);
                sb_q.delete();
                hold_exp = '0;
                iv8 = 1'b0;
                @(posedge clk); #1 rst = 1'b0;
            end else begin
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                c8  = 1'($urandom_range(0, 1));
                iv8 = 1'($urandom_range(0, 1));
                r9  = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
                if (iv8) sb_q.push_back(r9);
                #1;
                check("rand_comb", {23'd0, co8, s8}, {23'd0, r9});
            end
        end

        @(posedge clk); #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
